// File: rtl/varint_stream_enc.sv
// Streaming protobuf base-128 varint encoder: one value in, ceil(L/LANES) beats
// of up to LANES bytes out, with optional ZigZag mapping and backpressure.
module varint_stream_enc #(
    parameter int DATA_W = 64,
    parameter int LANES  = 1,
    parameter int NB_W   = $clog2(LANES + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    input  logic                 in_zigzag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic [NB_W-1:0]      out_nbytes,
    output logic                 out_last,
    output logic                 busy
);

    localparam int MAX_BYTES = (DATA_W + 6) / 7;
    localparam int SR_W      = 7 * MAX_BYTES;
    localparam int REM_W     = $clog2(MAX_BYTES + 1);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t               state_q, state_d;
    logic [SR_W-1:0]      sr_q, sr_d;
    logic [REM_W-1:0]     rem_q, rem_d;
    logic                 rdy_q, rdy_d;
    logic [8*LANES-1:0]   data_q, data_d;
    logic [NB_W-1:0]      nb_q, nb_d;
    logic                 last_q, last_d;

    logic [DATA_W-1:0]    v;
    logic [SR_W-1:0]      v_ext;
    logic [REM_W-1:0]     len;
    int                   n_rem;
    int                   n_beat;

    // Value mapping and minimal length: L is one past the highest non-zero 7-bit group.
    always_comb begin
        v = in_zigzag ? ((in_data << 1) ^ {DATA_W{in_data[DATA_W-1]}}) : in_data;
        v_ext = SR_W'(v);
        len = REM_W'(1);
        for (int k = 1; k < MAX_BYTES; k++) begin
            if (v_ext[7*k +: 7] != 7'd0) len = REM_W'(k + 1);
        end
    end

    // Next state; the beat registers are loaded from the next state so every
    // output is a flop and no in_* or out_ready path reaches an output.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        rem_d   = rem_q;
        if (state_q == IDLE) begin
            if (in_valid && rdy_q) begin
                state_d = EMIT;
                sr_d    = v_ext;
                rem_d   = len;
            end
        end else if (out_ready) begin
            sr_d  = sr_q >> (7 * LANES);
            rem_d = rem_q - REM_W'(nb_q);
            if (last_q) state_d = IDLE;
        end
        rdy_d = (state_d == IDLE);

        n_rem  = int'(rem_d);
        n_beat = (n_rem < LANES) ? n_rem : LANES;
        data_d = '0;
        nb_d   = '0;
        last_d = 1'b0;
        if (state_d == EMIT) begin
            for (int k = 0; k < LANES; k++) begin
                if (k < n_beat) data_d[8*k +: 8] = {(k + 1 < n_rem), sr_d[7*k +: 7]};
            end
            nb_d   = NB_W'(n_beat);
            last_d = (n_rem <= LANES);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            rem_q   <= '0;
            rdy_q   <= 1'b0;
            data_q  <= '0;
            nb_q    <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            rem_q   <= rem_d;
            rdy_q   <= rdy_d;
            data_q  <= data_d;
            nb_q    <= nb_d;
            last_q  <= last_d;
        end
    end

    assign in_ready   = rdy_q;
    assign out_valid  = (state_q == EMIT);
    assign busy       = (state_q == EMIT);
    assign out_data   = data_q;
    assign out_nbytes = nb_q;
    assign out_last   = last_q;

endmodule

// File: tb/tb_varint_stream_enc.sv
// Directed bench for varint_stream_enc: 64-bit/1-lane, 64-bit/4-lane and
// 32-bit/1-lane instances sharing clock and reset.
module tb_varint_stream_enc;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    // 64-bit, 1 lane
    logic        a_in_valid = 0, a_in_zigzag = 0, a_out_ready = 0;
    logic [63:0] a_in_data = '0;
    logic        a_in_ready, a_out_valid, a_out_last, a_busy;
    logic [7:0]  a_out_data;
    logic [0:0]  a_out_nbytes;
    // 64-bit, 4 lanes
    logic        b_in_valid = 0, b_in_zigzag = 0, b_out_ready = 0;
    logic [63:0] b_in_data = '0;
    logic        b_in_ready, b_out_valid, b_out_last, b_busy;
    logic [31:0] b_out_data;
    logic [2:0]  b_out_nbytes;
    // 32-bit, 1 lane
    logic        c_in_valid = 0, c_in_zigzag = 0, c_out_ready = 0;
    logic [31:0] c_in_data = '0;
    logic        c_in_ready, c_out_valid, c_out_last, c_busy;
    logic [7:0]  c_out_data;
    logic [0:0]  c_out_nbytes;

    varint_stream_enc #(.DATA_W(64), .LANES(1)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_zigzag(a_in_zigzag), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .out_nbytes(a_out_nbytes),
        .out_last(a_out_last), .busy(a_busy));

    varint_stream_enc #(.DATA_W(64), .LANES(4)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_zigzag(b_in_zigzag), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .out_nbytes(b_out_nbytes),
        .out_last(b_out_last), .busy(b_busy));

    varint_stream_enc #(.DATA_W(32), .LANES(1)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .in_zigzag(c_in_zigzag), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_data(c_out_data), .out_nbytes(c_out_nbytes),
        .out_last(c_out_last), .busy(c_busy));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_rdy(input int which);
        int t = 0;
        logic r;
        r = (which == 0) ? a_in_ready : (which == 1) ? b_in_ready : c_in_ready;
        while (!r && t < 20) begin
            @(negedge clk);
            t++;
            r = (which == 0) ? a_in_ready : (which == 1) ? b_in_ready : c_in_ready;
        end
        if (!r) chk("rdy_timeout", 64'(r), 64'd1);
    endtask

    // 64-bit/1-lane: exp holds byte i at bits 8i+7:8i
    task automatic send_a(input string tag, input logic [63:0] d, input logic zz,
                          input int n, input logic [79:0] exp);
        wait_rdy(0);
        a_in_data = d; a_in_zigzag = zz; a_in_valid = 1'b1; a_out_ready = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk(tag, {a_out_valid, a_out_last, a_in_ready, a_busy, a_out_nbytes, a_out_data},
                {1'b1, (i == n - 1), 1'b0, 1'b1, 1'b1, exp[8*i +: 8]});
            @(negedge clk);
        end
        chk({tag, "_done"}, {a_out_valid, a_in_ready, a_busy}, 3'b010);
    endtask

    task automatic send_b(input string tag, input logic [63:0] d, input int n,
                          input logic [3:0][2:0] nb, input logic [3:0][31:0] dat);
        wait_rdy(1);
        b_in_data = d; b_in_zigzag = 1'b0; b_in_valid = 1'b1; b_out_ready = 1'b1;
        @(negedge clk);
        b_in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk(tag, {b_out_valid, b_out_last, b_in_ready, b_out_nbytes, b_out_data},
                {1'b1, (i == n - 1), 1'b0, nb[i], dat[i]});
            @(negedge clk);
        end
        chk({tag, "_done"}, {b_out_valid, b_in_ready}, 2'b01);
    endtask

    task automatic send_c(input string tag, input logic [31:0] d, input logic zz,
                          input int n, input logic [39:0] exp);
        wait_rdy(2);
        c_in_data = d; c_in_zigzag = zz; c_in_valid = 1'b1; c_out_ready = 1'b1;
        @(negedge clk);
        c_in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk(tag, {c_out_valid, c_out_last, c_in_ready, c_out_nbytes, c_out_data},
                {1'b1, (i == n - 1), 1'b0, 1'b1, exp[8*i +: 8]});
            @(negedge clk);
        end
        chk({tag, "_done"}, {c_out_valid, c_in_ready}, 2'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_a", {a_in_ready, a_out_valid, a_out_last, a_busy, a_out_nbytes, a_out_data}, '0);
        chk("rst_b", {b_in_ready, b_out_valid, b_out_last, b_busy, b_out_nbytes, b_out_data}, '0);
        chk("rst_c", {c_in_ready, c_out_valid, c_out_last, c_busy, c_out_nbytes, c_out_data}, '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rise", {a_in_ready, b_in_ready, c_in_ready, a_out_valid}, 4'b1110);

        // 64-bit, 1 lane
        send_a("zero",  64'd0,   1'b0, 1, 80'h00);
        send_a("d300",  64'd300, 1'b0, 2, 80'h02AC);
        send_a("ones",  '1,      1'b0, 10, 80'h01FFFFFFFFFFFFFFFFFF);
        send_a("zz_m1", '1,      1'b1, 1, 80'h01);
        send_a("zz_m64", 64'hFFFF_FFFF_FFFF_FFC0, 1'b1, 1, 80'h7F);
        send_a("zz_64", 64'd64,  1'b1, 2, 80'h0180);

        // 32-bit, 1 lane
        send_c("c_zzmin", 32'h8000_0000, 1'b1, 5, 40'h0FFFFFFFFF);
        send_c("c_127",   32'd127,       1'b0, 1, 40'h7F);
        send_c("c_128",   32'd128,       1'b0, 2, 40'h0180);

        // 64-bit, 4 lanes
        send_b("b_ones", '1, 3, {3'd0, 3'd2, 3'd4, 3'd4},
               {32'h0, 32'h0000_01FF, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
        send_b("b_300", 64'd300, 1, {3'd0, 3'd0, 3'd0, 3'd2},
               {32'h0, 32'h0, 32'h0, 32'h0000_02AC});
        send_b("b_zero", 64'd0, 1, {3'd0, 3'd0, 3'd0, 3'd1},
               {32'h0, 32'h0, 32'h0, 32'h0});
        send_b("b_2p28", 64'h1000_0000, 2, {3'd0, 3'd0, 3'd1, 3'd4},
               {32'h0, 32'h0, 32'h0000_0001, 32'h8080_8080});

        // Backpressure on the second beat of 300
        wait_rdy(0);
        a_in_data = 64'd300; a_in_zigzag = 1'b0; a_in_valid = 1'b1; a_out_ready = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0;
        chk("bp_b0", {a_out_valid, a_out_last, a_out_data}, {2'b10, 8'hAC});
        @(negedge clk);
        a_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("bp_hold", {a_out_valid, a_out_last, a_in_ready, a_out_nbytes, a_out_data},
                {4'b1101, 8'h02});
            if (i < 3) @(negedge clk);
        end
        a_out_ready = 1'b1;
        @(negedge clk);
        chk("bp_idle", {a_out_valid, a_in_ready}, 2'b01);
        a_in_data = 64'd5; a_in_valid = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0;
        chk("bp_next", {a_out_valid, a_out_last, a_out_data}, {2'b11, 8'h05});
        @(negedge clk);
        chk("bp_next_done", {a_out_valid, a_in_ready}, 2'b01);

        // Reset during beat 3 of 2^64-1
        a_in_data = '1; a_in_zigzag = 1'b0; a_in_valid = 1'b1; a_out_ready = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mr_b3", {a_out_valid, a_out_last, a_out_data}, {2'b10, 8'hFF});
        rst_n = 1'b0;
        a_in_data = 64'd1; a_in_valid = 1'b1;
        @(negedge clk);
        chk("mr_zero", {a_in_ready, a_out_valid, a_out_last, a_busy, a_out_nbytes, a_out_data}, '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_rdy", {a_out_valid, a_in_ready}, 2'b01);
        @(negedge clk);
        a_in_valid = 1'b0;
        chk("mr_next", {a_out_valid, a_out_last, a_out_nbytes, a_out_data}, {3'b111, 8'h01});
        @(negedge clk);
        chk("mr_done", {a_out_valid, a_in_ready, a_busy}, 3'b010);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
